// File: rtl/pmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pmem_responder
//
// Memory-side responder for the core's load/store and fetch accesses. It takes
// one request at a time on a valid/ready request channel, waits a programmable
// number of cycles, performs the access and returns the result on a
// valid/ready response channel. The pipeline can then be exercised against a
// multi-cycle memory instead of a combinational one.
//
// The simulator's pmem_read/pmem_write hooks are realised here as a
// word-addressed backing store. It holds 2**MEM_AW 64-bit words, indexed by the
// aligned word address modulo the depth. This keeps the block self-contained
// and synthesizable. Addresses outside [BASE, BASE+SIZE) never reach the store.
//
// Optional build macro:
//   PMEM_RAND_DELAY_EN - adds 0..3 extra wait cycles per request, taken from a
//                        free-running 16-bit LFSR (taps 16,14,13,11, seed
//                        16'hACE1).
//
// Parameters:
//   LATENCY  wait cycles between acceptance and access/response (0..255)
//   BASE     first valid byte address
//   SIZE     size of the valid window in bytes
//   MEM_AW   log2 of the backing store depth in 64-bit words
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   req_valid   request present
//   req_ready   responder can accept a request
//   req_wen     1 = write, 0 = read
//   req_addr    byte address; bits [2:0] are ignored for the access
//   req_wdata   lane-aligned write data
//   req_wmask   byte enables for writes
//   resp_valid  response present
//   resp_ready  initiator accepts the response
//   resp_rdata  read data (0 for writes and errors)
//   resp_err    address was outside [BASE, BASE+SIZE)
//   rd_count    completed reads, wrapping
//   wr_count    completed writes, wrapping
// -----------------------------------------------------------------------------
module pmem_responder #(
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter logic [63:0] SIZE    = 64'h0800_0000,
    parameter int unsigned MEM_AW  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [8:0] LAT9 = 9'(LATENCY);

    state_t state;
    state_t state_nxt;

    // Goes high on the first edge after reset so req_ready stays low for that
    // first cycle even though the state is already IDLE.
    logic primed;

    // Wide enough for LATENCY (255 max) plus up to 3 random extra cycles.
    logic [8:0] cnt;
    logic [8:0] start_cnt;

    logic              lat_wen;
    logic [MEM_AW-1:0] lat_idx;
    logic [63:0]       lat_wdata;
    logic [7:0]        lat_wmask;
    logic              lat_err;

    logic              addr_bad;
    logic              accept;
    logic              access;
    logic              resp_done;
    logic              acc_wen;
    logic [MEM_AW-1:0] acc_idx;
    logic [63:0]       acc_wdata;
    logic [7:0]        acc_wmask;
    logic              acc_err;

    logic [63:0] mem [2**MEM_AW];

    function automatic logic [63:0] pmem_read(input logic [MEM_AW-1:0] idx);
        return mem[idx];
    endfunction

    // The range check uses the unaligned address. Subtracting BASE first keeps
    // the upper bound from overflowing.
    assign addr_bad = (req_addr < BASE) || ((req_addr - BASE) >= SIZE);

`ifdef PMEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // The LFSR advances every cycle, idle or not. Its low two bits at the
    // acceptance edge stretch that request's wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign start_cnt = LAT9 + {7'd0, lfsr[1:0]};
`else
    assign start_cnt = LAT9;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A zero wait count goes straight to RESP from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (start_cnt == 9'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 9'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output and control decode. An access at the acceptance edge uses the
    // live request. A delayed access uses the copy latched at acceptance.
    always_comb begin
        req_ready  = (state == IDLE) && primed;
        resp_valid = (state == RESP);
        accept     = req_ready && req_valid;
        resp_done  = resp_valid && resp_ready;
        access     = (accept && (start_cnt == 9'd0)) ||
                     ((state == WAIT) && (cnt == 9'd1));
        if (state == IDLE) begin
            acc_wen   = req_wen;
            acc_idx   = req_addr[MEM_AW+2:3];
            acc_wdata = req_wdata;
            acc_wmask = req_wmask;
            acc_err   = addr_bad;
        end else begin
            acc_wen   = lat_wen;
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
            acc_wmask = lat_wmask;
            acc_err   = lat_err;
        end
    end

    // Request capture, wait counter, response registers and completion
    // counters. Counters move only for in-range accesses. A mask-less write
    // still counts as a completed write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed     <= 1'b0;
            cnt        <= 9'd0;
            lat_wen    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 64'd0;
            lat_wmask  <= 8'd0;
            lat_err    <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
            rd_count   <= 32'd0;
            wr_count   <= 32'd0;
        end else begin
            primed <= 1'b1;
            if (accept) begin
                lat_wen   <= req_wen;
                lat_idx   <= req_addr[MEM_AW+2:3];
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask;
                lat_err   <= addr_bad;
                cnt       <= start_cnt;
            end else if (state == WAIT) begin
                cnt <= cnt - 9'd1;
            end
            if (access) begin
                if (acc_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 64'd0;
                end else if (acc_wen) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= 64'd0;
                    wr_count   <= wr_count + 32'd1;
                end else begin
                    resp_err   <= 1'b0;
                    resp_rdata <= pmem_read(acc_idx);
                    rd_count   <= rd_count + 32'd1;
                end
            end else if (resp_done) begin
                resp_err   <= 1'b0;
                resp_rdata <= 64'd0;
            end
        end
    end

    // Backing-store write port. This is the pmem_write path. It never fires
    // during reset, because reset holds the FSM in IDLE with req_ready low.
    always_ff @(posedge clk) begin
        if (access && acc_wen && !acc_err) begin
            for (int b = 0; b < 8; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pmem_responder
//
// Three responders share one clock: LATENCY 2, 0 and 4. A transaction-level
// model predicts every output of each instance. The model tracks readiness,
// the wait in edges, response contents, counters and a byte-addressed memory.
// A single compare process checks all instances on every falling edge.
// Directed sequences add literal checks on latency, data, error and counters.
// -----------------------------------------------------------------------------
module tb_pmem_responder;

    localparam int          NI   = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SIZE = 64'h0800_0000;

    logic        clk;
    logic        rst        [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_wen    [NI];
    logic [63:0] req_addr   [NI];
    logic [63:0] req_wdata  [NI];
    logic [7:0]  req_wmask  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [63:0] resp_rdata [NI];
    logic        resp_err   [NI];
    logic [31:0] rd_count   [NI];
    logic [31:0] wr_count   [NI];

    int total = 0;
    int bad   = 0;

    function automatic int latOf(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pmem_responder #(
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 4))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_wen    (req_wen[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_wmask  (req_wmask[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .rd_count   (rd_count[g]),
            .wr_count   (wr_count[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, one entry per instance.
    bit          m_ready [NI];
    bit          m_valid [NI];
    bit          m_err   [NI];
    logic [63:0] m_rdata [NI];
    int          m_wait  [NI];
    logic [31:0] m_rd    [NI];
    logic [31:0] m_wr    [NI];
    logic [15:0] m_lfsr  [NI];
    bit          p_wen   [NI];
    logic [63:0] p_addr  [NI];
    logic [63:0] p_wdata [NI];
    logic [7:0]  p_wmask [NI];
    logic [63:0] m_mem   [bit [63:0]];

    // Perform the pending access of instance i on the model memory.
    task automatic modelAccess(input int i);
        logic [63:0] a;
        logic [63:0] w;
        bit   [63:0] key;
        a   = p_addr[i];
        key = (a & ~64'h7) | (64'(i) << 40);
        if (a < BASE || a >= BASE + SIZE) begin
            m_err[i]   = 1'b1;
            m_rdata[i] = 64'd0;
        end else if (p_wen[i]) begin
            w = m_mem.exists(key) ? m_mem[key] : 64'd0;
            for (int b = 0; b < 8; b++) begin
                if (p_wmask[i][b]) w[b*8 +: 8] = p_wdata[i][b*8 +: 8];
            end
            m_mem[key] = w;
            m_wr[i]    = m_wr[i] + 32'd1;
            m_err[i]   = 1'b0;
            m_rdata[i] = 64'd0;
        end else begin
            m_rdata[i] = m_mem.exists(key) ? m_mem[key] : 64'd0;
            m_rd[i]    = m_rd[i] + 32'd1;
            m_err[i]   = 1'b0;
        end
        m_valid[i] = 1'b1;
    endtask

    // Model update on every rising edge. The model is cleared whenever reset
    // is low. The compare process handles the asynchronous part of reset.
    always @(posedge clk) begin
        logic [1:0] extra;
        for (int i = 0; i < NI; i++) begin
            if (rst[i] !== 1'b1) begin
                m_ready[i] = 1'b0;
                m_valid[i] = 1'b0;
                m_err[i]   = 1'b0;
                m_rdata[i] = 64'd0;
                m_wait[i]  = 0;
                m_rd[i]    = 32'd0;
                m_wr[i]    = 32'd0;
                m_lfsr[i]  = 16'hACE1;
            end else begin
                extra = 2'd0;
`ifdef PMEM_RAND_DELAY_EN
                extra = m_lfsr[i][1:0];
                m_lfsr[i] = {m_lfsr[i][14:0],
                             m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
`endif
                if (m_valid[i]) begin
                    if (resp_ready[i]) begin
                        m_valid[i] = 1'b0;
                        m_err[i]   = 1'b0;
                        m_rdata[i] = 64'd0;
                        m_ready[i] = 1'b1;
                    end
                end else if (m_wait[i] > 0) begin
                    m_wait[i] = m_wait[i] - 1;
                    if (m_wait[i] == 0) modelAccess(i);
                end else if (m_ready[i]) begin
                    if (req_valid[i]) begin
                        p_wen[i]   = req_wen[i];
                        p_addr[i]  = req_addr[i];
                        p_wdata[i] = req_wdata[i];
                        p_wmask[i] = req_wmask[i];
                        m_ready[i] = 1'b0;
                        m_wait[i]  = latOf(i) + int'(extra);
                        if (m_wait[i] == 0) modelAccess(i);
                    end
                end else begin
                    m_ready[i] = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic checkLat(input string name, input int i, input int lat);
        bit ok;
`ifdef PMEM_RAND_DELAY_EN
        ok = (lat >= latOf(i) + 1) && (lat <= latOf(i) + 4);
`else
        ok = (lat == latOf(i) + 1);
`endif
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected LATENCY+1 with LATENCY=%0d",
                     name, lat, latOf(i));
        end
    endtask

    // Compare process. Every instance is checked against the model on each
    // falling edge. While reset is low, the reset values are expected.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i] === 1'b0) begin
                checkOutput($sformatf("inst%0d rst req_ready", i), 64'(req_ready[i]), 64'd0);
                checkOutput($sformatf("inst%0d rst resp_valid", i), 64'(resp_valid[i]), 64'd0);
                checkOutput($sformatf("inst%0d rst resp_err", i), 64'(resp_err[i]), 64'd0);
                checkOutput($sformatf("inst%0d rst resp_rdata", i), resp_rdata[i], 64'd0);
                checkOutput($sformatf("inst%0d rst rd_count", i), 64'(rd_count[i]), 64'd0);
                checkOutput($sformatf("inst%0d rst wr_count", i), 64'(wr_count[i]), 64'd0);
            end else begin
                checkOutput($sformatf("inst%0d req_ready", i), 64'(req_ready[i]), 64'(m_ready[i]));
                checkOutput($sformatf("inst%0d resp_valid", i), 64'(resp_valid[i]), 64'(m_valid[i]));
                checkOutput($sformatf("inst%0d resp_err", i), 64'(resp_err[i]), 64'(m_err[i]));
                if (m_valid[i]) begin
                    checkOutput($sformatf("inst%0d resp_rdata", i), resp_rdata[i], m_rdata[i]);
                end
                checkOutput($sformatf("inst%0d rd_count", i), 64'(rd_count[i]), 64'(m_rd[i]));
                checkOutput($sformatf("inst%0d wr_count", i), 64'(wr_count[i]), 64'(m_wr[i]));
            end
        end
    end

    // One full transaction with resp_ready held high. Returns the number of
    // falling edges from the acceptance edge until resp_valid is seen, and
    // the response fields captured at that point.
    task automatic applyStimulus(input int i, input bit wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] wmask,
                                 output int lat, output logic [63:0] rdata, output logic err);
        int n;
        @(negedge clk);
        req_valid[i]  = 1'b1;
        req_wen[i]    = wen;
        req_addr[i]   = addr;
        req_wdata[i]  = wdata;
        req_wmask[i]  = wmask;
        resp_ready[i] = 1'b1;
        n = 0;
        while (!m_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready[i]) begin
            total++;
            bad++;
            $display("[TB] FAIL inst%0d accept timeout: got no acceptance, expected one within 50 cycles", i);
            req_valid[i] = 1'b0;
            lat   = -1;
            rdata = 'x;
            err   = 1'bx;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 1;
        while (resp_valid[i] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        rdata = resp_rdata[i];
        err   = resp_err[i];
        @(negedge clk);
    endtask

    task automatic doTxn(input string name, input int i, input bit wen,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input logic [63:0] exp_rdata,
                         input bit exp_err);
        int          lat;
        logic [63:0] rdata;
        logic        err;
        applyStimulus(i, wen, addr, wdata, wmask, lat, rdata, err);
        checkLat(name, i, lat);
        checkOutput({name, " rdata"}, rdata, exp_rdata);
        checkOutput({name, " err"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            rst[i]        = 1'b0;
            req_valid[i]  = 1'b0;
            req_wen[i]    = 1'b0;
            req_addr[i]   = 64'd0;
            req_wdata[i]  = 64'd0;
            req_wmask[i]  = 8'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 64'(req_ready[0]), 64'd0);
        for (int i = 0; i < NI; i++) rst[i] = 1'b1;
        @(negedge clk);
        checkOutput("req_ready after release", 64'(req_ready[0]), 64'd1);

        // Basic write/read, alignment, masks and counters.
        doTxn("wr 0x10", 0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0);
        checkOutput("wr_count after first write", 64'(wr_count[0]), 64'd1);
        doTxn("rd 0x10", 0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);
        checkOutput("rd_count after first read", 64'(rd_count[0]), 64'd1);
        doTxn("rd 0x14 aligned", 0, 1'b0, 64'h8000_0014, 64'd0, 8'h00, 64'h1122334455667788, 1'b0);
        doTxn("wr mask 0F", 0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0, 1'b0);
        doTxn("rd after mask 0F", 0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0);
        doTxn("wr mask 00", 0, 1'b1, 64'h8000_0010, 64'd0, 8'h00, 64'd0, 1'b0);
        checkOutput("wr_count after empty mask", 64'(wr_count[0]), 64'd3);
        doTxn("rd after mask 00", 0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h11223344FFFFFFFF, 1'b0);

        // Window bounds.
        doTxn("rd below BASE", 0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
        doTxn("rd BASE+SIZE", 0, 1'b0, 64'h8800_0000, 64'd0, 8'h00, 64'd0, 1'b1);
        checkOutput("rd_count after errors", 64'(rd_count[0]), 64'd4);
        doTxn("wr top word", 0, 1'b1, 64'h87FF_FFF8, 64'hCAFEF00DDEADBEEF, 8'hFF, 64'd0, 1'b0);
        doTxn("rd top word", 0, 1'b0, 64'h87FF_FFF8, 64'd0, 8'h00, 64'hCAFEF00DDEADBEEF, 1'b0);
        doTxn("rd last byte", 0, 1'b0, 64'h87FF_FFFF, 64'd0, 8'h00, 64'hCAFEF00DDEADBEEF, 1'b0);
        doTxn("wr BASE+SIZE", 0, 1'b1, 64'h8800_0000, 64'h5A5A, 8'hFF, 64'd0, 1'b1);
        checkOutput("wr_count after error write", 64'(wr_count[0]), 64'd4);

        // Response back-pressure with a second request held on the channel.
        @(negedge clk);
        resp_ready[0] = 1'b0;
        req_valid[0]  = 1'b1;
        req_wen[0]    = 1'b0;
        req_addr[0]   = 64'h8000_0010;
        n = 0;
        while (!m_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_addr[0] = 64'h87FF_FFF8;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checkOutput("stall resp_valid", 64'(resp_valid[0]), 64'd1);
        checkOutput("stall req_ready", 64'(req_ready[0]), 64'd0);
        checkOutput("stall resp_rdata", resp_rdata[0], 64'h11223344FFFFFFFF);
        resp_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput("release resp_valid", 64'(resp_valid[0]), 64'd0);
        checkOutput("release req_ready", 64'(req_ready[0]), 64'd1);
        @(negedge clk);
        checkOutput("held request accepted", 64'(req_ready[0]), 64'd0);
        req_valid[0] = 1'b0;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held request rdata", resp_rdata[0], 64'hCAFEF00DDEADBEEF);
        @(negedge clk);
        checkOutput("rd_count after stall", 64'(rd_count[0]), 64'd8);

        // Many reads of known data; latency is checked on each.
        for (int j = 0; j < 8; j++) begin
            doTxn("fill", 0, 1'b1, 64'h8000_0200 + 64'(8 * j),
                  64'h0101010101010101 * 64'(j + 1), 8'hFF, 64'd0, 1'b0);
        end
        for (int k = 0; k < 100; k++) begin
            doTxn("sweep rd", 0, 1'b0, 64'h8000_0200 + 64'(8 * (k % 8)) + 64'(k % 3),
                  64'd0, 8'h00, 64'h0101010101010101 * 64'((k % 8) + 1), 1'b0);
        end

        // Zero-latency instance.
        doTxn("L0 wr", 1, 1'b1, 64'h8000_0020, 64'h0F0E0D0C0B0A0908, 8'hFF, 64'd0, 1'b0);
        doTxn("L0 rd", 1, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 64'h0F0E0D0C0B0A0908, 1'b0);

        // Reset during the wait of a write on the LATENCY=4 instance.
        doTxn("L4 wr", 2, 1'b1, 64'h8000_0100, 64'hAAAA5555AAAA5555, 8'hFF, 64'd0, 1'b0);
        @(negedge clk);
        resp_ready[2] = 1'b1;
        req_valid[2]  = 1'b1;
        req_wen[2]    = 1'b1;
        req_addr[2]   = 64'h8000_0100;
        req_wdata[2]  = 64'h0123456789ABCDEF;
        req_wmask[2]  = 8'hFF;
        n = 0;
        while (!m_ready[2] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        #2;
        rst[2] = 1'b0;
        #1;
        checkOutput("async rst req_ready", 64'(req_ready[2]), 64'd0);
        checkOutput("async rst resp_valid", 64'(resp_valid[2]), 64'd0);
        checkOutput("async rst wr_count", 64'(wr_count[2]), 64'd0);
        repeat (8) @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        doTxn("L4 rd after rst", 2, 1'b0, 64'h8000_0100, 64'd0, 8'h00, 64'hAAAA5555AAAA5555, 1'b0);
        checkOutput("L4 wr_count after rst", 64'(wr_count[2]), 64'd0);
        checkOutput("L4 rd_count after rst", 64'(rd_count[2]), 64'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Memory-side responder for the core's load/store and fetch accesses.
- Accepts one request at a time on a valid/ready request channel.
- Performs the access through the DPI-C pmem_read/pmem_write functions after a programmable latency.
- Returns data on a valid/ready response channel. Replaces the core's direct combinational DPI calls so the pipeline can be tested against a multi-cycle memory.

Parameters:
- LATENCY, 2: wait cycles between request acceptance and the access/response (0..255).
- BASE, 64'h8000_0000: first valid byte address.
- SIZE, 64'h0800_0000: size of the valid window in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  64  byte address. Bits [2:0] are ignored for the access (8-byte aligned).
- req_wdata  in  64  write data, lane-aligned.
- req_wmask  in  8  byte-enable for writes.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  64  read data (0 for writes and errors).
- resp_err  out  1  address outside [BASE, BASE+SIZE).
- rd_count  out  32  completed reads, wrapping.
- wr_count  out  32  completed writes, wrapping.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, rd_count=0, wr_count=0.
  - req_ready rises on the first clk edge after rst releases.
- States: IDLE, WAIT, RESP. Only one request is outstanding at a time.
- IDLE: req_ready=1. On an edge with req_valid&&req_ready:
  - Latch wen, aligned addr (addr & ~7), wdata and wmask.
  - req_ready goes 0 at that edge.
  - If LATENCY==0: perform the access at that edge and go to RESP. Otherwise load cnt=LATENCY and go to WAIT.
- WAIT: cnt decrements every cycle. On the edge where cnt==1: perform the access and go to RESP.
- Access:
  - Out of range: resp_err=1, resp_rdata=0, no DPI call, no counter change.
  - Read: pmem_read(aligned addr) → resp_rdata; rd_count+1.
  - Write: pmem_write(aligned addr, wdata, wmask); resp_rdata=0; wr_count+1.
  - Write with wmask==0: no DPI call, wr_count still +1, normal response.
- Timing: resp_valid=1 exactly LATENCY+1 cycles after the acceptance edge.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On that edge: resp_valid=0, resp_err=0, state=IDLE, req_ready=1 (new request accepted from the next edge).
  - No back-to-back accept in the response-completion cycle.
- req_valid while req_ready=0 is ignored. The initiator must hold the request; the responder does not latch it.
- Address bounds: addr==BASE+SIZE-1 is in range; BASE+SIZE is out of range. The comparison uses the unaligned req_addr.
- Counters wrap from 0xFFFF_FFFF to 0.
- Reset mid-operation: state returns to IDLE immediately and the pending request is dropped with no response. A write already issued to DPI is not undone; an unissued write is never performed.
- Inputs are sampled only at the acceptance edge; changes afterwards have no effect.

Optional Feature:
- Macro: PMEM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle, including idle cycles.
  - At acceptance, lfsr[1:0] (0..3) is added to the wait count, so resp_valid arrives LATENCY+1+lfsr[1:0] cycles after acceptance.
  - With LATENCY==0 and lfsr[1:0]!=0, the block passes through WAIT.
- Undefined: latency is fixed at LATENCY+1 and no LFSR exists.

Test Plan:
- LATENCY=2: write addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF, resp_ready=1 → resp_valid on the 3rd edge after acceptance, resp_err=0, wr_count=1. Then read the same address → resp_rdata=0x1122334455667788, rd_count=1.
- Read addr 0x8000_0014 → same data as 0x8000_0010, because the address is aligned to 8 bytes.
- Read addr 0x7FFF_FFF8, then BASE+SIZE → resp_err=1, resp_rdata=0, rd_count unchanged. Read BASE+SIZE-8 → resp_err=0.
- Hold resp_ready=0 for 5 cycles while req_valid stays 1 with a new request → resp_valid and resp_rdata stay stable, req_ready=0, second request not accepted. Raise resp_ready → req_ready=1 next cycle, then the second request is accepted.
- LATENCY=0 → resp_valid 1 cycle after acceptance. Drive rst=0 during WAIT of a LATENCY=4 write → outputs cleared asynchronously, memory at that address unchanged, wr_count=0.
- With PMEM_RAND_DELAY_EN, 100 reads → every latency falls in [LATENCY+1, LATENCY+4] and all read data is correct.
